// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED matrix sequencer: FSM states, pattern
// modes, per-pattern frame lengths and the blank / initial row-column codes.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_WALK     = 2'd0,
        MODE_BOUNCE   = 2'd1,
        MODE_BLINK    = 2'd2,
        MODE_WALK_ALT = 2'd3
    } mode_e;

    localparam logic [5:0] WALK_FRAME_TICKS   = 6'd32;
    localparam logic [5:0] BOUNCE_FRAME_TICKS = 6'd14;
    localparam logic [5:0] BLINK_FRAME_TICKS  = 6'd2;

    // Row/column selects are active-low: all ones is a dark matrix.
    localparam logic [3:0] X_BLANK  = 4'hF;
    localparam logic [7:0] Y_BLANK  = 8'hFF;
    localparam logic [3:0] X_INIT   = 4'b1110;
    localparam logic [7:0] Y_INIT   = 8'b1111_1110;
    localparam logic [3:0] X_ALL_ON = 4'h0;
    localparam logic [7:0] Y_ALL_ON = 8'h00;

    function automatic logic [5:0] frame_ticks(input mode_e m);
        logic [5:0] n;
        case (m)
            MODE_BOUNCE: n = BOUNCE_FRAME_TICKS;
            MODE_BLINK:  n = BLINK_FRAME_TICKS;
            default:     n = WALK_FRAME_TICKS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step-period divider: counts 0..div and flags tick on the terminal count.
// clr holds the count at zero so the first tick lands div+1 cycles after release.
module led_tick_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = !clr && (cnt == div);

endmodule

// File: rtl/led_matrix_sequencer.sv
// LED matrix pattern sequencer (WALK / BOUNCE / BLINK) with registered outputs.
// Optional build macro LED_SEQ_LOOP_EN: frames=0 plays until stopped.
module led_matrix_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int FRM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [FRM_W-1:0] frames,
    output logic             busy,
    output logic             done,
    output logic             step_tick,
    output logic [3:0]       x,
    output logic [7:0]       y
);

    state_e           state;
    mode_e            mode_q;
    logic [DIV_W-1:0] div_q;
    logic [FRM_W-1:0] frames_q;
    logic [FRM_W-1:0] frames_eff;
    logic [FRM_W-1:0] frame_cnt;
    logic [FRM_W-1:0] frame_nxt;
    logic [5:0]       tick_cnt;
    logic             bounce_dn;

    logic             tick;
    logic             div_clr;
    logic             tick_last;
    logic             frame_last;
    logic [3:0]       x_adv;
    logic [7:0]       y_adv;
    logic             dn_adv;

    assign div_clr = (state != ST_RUN);

    led_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .div   (div_q),
        .tick  (tick)
    );

    assign frame_nxt = frame_cnt + FRM_W'(1);
    assign tick_last = (tick_cnt == (frame_ticks(mode_q) - 6'd1));

`ifdef LED_SEQ_LOOP_EN
    // frames=0 never matches, so the frame counter simply wraps.
    assign frames_eff = frames;
    assign frame_last = (frames_q != '0) && (frame_nxt == frames_q);
`else
    assign frames_eff = (frames == '0) ? FRM_W'(1) : frames;
    assign frame_last = (frame_nxt == frames_q);
`endif

    // Next pattern for one step of the latched mode.
    always_comb begin
        x_adv  = x;
        y_adv  = y;
        dn_adv = bounce_dn;
        case (mode_q)
            MODE_BOUNCE: begin
                if (!bounce_dn) begin
                    y_adv = {y[6:0], 1'b1};
                    if (!y_adv[7]) dn_adv = 1'b1;
                end else begin
                    y_adv = {1'b1, y[7:1]};
                    if (!y_adv[0]) dn_adv = 1'b0;
                end
            end
            MODE_BLINK: begin
                x_adv = ~x;
                y_adv = ~y;
            end
            default: begin
                y_adv = {y[6:0], y[7]};
                if (y == 8'b0111_1111) x_adv = {x[2:0], x[3]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_WALK;
            div_q     <= '0;
            frames_q  <= '0;
            frame_cnt <= '0;
            tick_cnt  <= '0;
            bounce_dn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_tick <= 1'b0;
            x         <= X_BLANK;
            y         <= Y_BLANK;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    x <= X_BLANK;
                    y <= Y_BLANK;
                    if (start && !stop) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        mode_q   <= mode_e'(mode);
                        div_q    <= div;
                        frames_q <= frames_eff;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        x     <= X_BLANK;
                        y     <= Y_BLANK;
                    end else begin
                        state     <= ST_RUN;
                        frame_cnt <= '0;
                        tick_cnt  <= '0;
                        bounce_dn <= 1'b0;
                        if (mode_q == MODE_BLINK) begin
                            x <= X_ALL_ON;
                            y <= Y_ALL_ON;
                        end else begin
                            x <= X_INIT;
                            y <= Y_INIT;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        x     <= X_BLANK;
                        y     <= Y_BLANK;
                    end else if (tick) begin
                        step_tick <= 1'b1;
                        x         <= x_adv;
                        y         <= y_adv;
                        bounce_dn <= dn_adv;
                        if (tick_last) begin
                            tick_cnt  <= '0;
                            frame_cnt <= frame_nxt;
                            if (frame_last) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                x     <= X_BLANK;
                                y     <= Y_BLANK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    x     <= X_BLANK;
                    y     <= Y_BLANK;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_sequencer.sv
// Directed bench for led_matrix_sequencer: reset, WALK/BLINK/BOUNCE sequences,
// stop/abort, start+stop in IDLE, reset mid-run and frames=0 handling.
module tb_led_matrix_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [7:0]  frames;
    logic        busy;
    logic        done;
    logic        step_tick;
    logic [3:0]  x;
    logic [7:0]  y;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_base;
    int cyc;
    logic [7:0] exp_q[$];

    led_matrix_sequencer #(
        .DIV_W (24),
        .FRM_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .div       (div),
        .frames    (frames),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick),
        .x         (x),
        .y         (y)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start_seq(input logic [1:0] m, input logic [23:0] d, input logic [7:0] f);
        @(negedge clk);
        mode   = m;
        div    = d;
        frames = f;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_tick !== 1'b1 && n < budget);
        chk("tick_seen", {31'd0, step_tick}, 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 2'd0;
        div    = 24'd0;
        frames = 8'd1;

        // reset for two cycles
        repeat (2) @(negedge clk);
        chk("rst_x", {28'd0, x}, 32'hF);
        chk("rst_y", {24'd0, y}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tick", {31'd0, step_tick}, 32'd0);
        reset = 1'b0;

        // WALK, div=0, frames=1
        done_base = done_cnt;
        start_seq(2'd0, 24'd0, 8'd1);
        chk("walk_busy_load", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("walk_init_x", {28'd0, x}, 32'hE);
        chk("walk_init_y", {24'd0, y}, 32'hFE);
        for (int k = 1; k <= 32; k++) begin
            wait_tick(4, cyc);
            if (k == 1) begin
                chk("walk_first_lat", cyc, 32'd1);
                chk("walk_t1_y", {24'd0, y}, 32'hFD);
            end
            if (k == 8) begin
                chk("walk_t8_y", {24'd0, y}, 32'hFE);
                chk("walk_t8_x", {28'd0, x}, 32'hD);
            end
            if (k == 16) chk("walk_t16_x", {28'd0, x}, 32'hB);
            if (k == 31) begin
                chk("walk_t31_y", {24'd0, y}, 32'h7F);
                chk("walk_t31_x", {28'd0, x}, 32'h7);
                chk("walk_t31_done", {31'd0, done}, 32'd0);
            end
            if (k == 32) begin
                chk("walk_done", {31'd0, done}, 32'd1);
                chk("walk_done_x", {28'd0, x}, 32'hF);
                chk("walk_done_y", {24'd0, y}, 32'hFF);
            end
        end
        @(negedge clk);
        chk("walk_idle_done", {31'd0, done}, 32'd0);
        chk("walk_idle_busy", {31'd0, busy}, 32'd0);
        chk("walk_done_count", done_cnt - done_base, 32'd1);

        // BLINK, div=3, frames=2; inputs changed while busy must not matter
        done_base = done_cnt;
        start_seq(2'd2, 24'd3, 8'd2);
        mode   = 2'd0;
        div    = 24'd0;
        frames = 8'd9;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("blink_init_x", {28'd0, x}, 32'h0);
        chk("blink_init_y", {24'd0, y}, 32'h00);
        for (int k = 1; k <= 4; k++) begin
            wait_tick(8, cyc);
            chk("blink_period", cyc, 32'd4);
            if (k == 2) begin
                chk("blink_t2_x", {28'd0, x}, 32'h0);
                chk("blink_t2_y", {24'd0, y}, 32'h00);
            end else begin
                chk("blink_on_x", {28'd0, x}, 32'hF);
                chk("blink_on_y", {24'd0, y}, 32'hFF);
            end
            chk("blink_done", {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("blink_done_count", done_cnt - done_base, 32'd1);

        // BOUNCE, div=0, frames=1
        exp_q = {8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD};
        done_base = done_cnt;
        start_seq(2'd1, 24'd0, 8'd1);
        @(negedge clk);
        chk("bounce_init_y", {24'd0, y}, 32'hFE);
        for (int k = 1; k <= 14; k++) begin
            wait_tick(4, cyc);
            if (k < 14) begin
                chk("bounce_y", {24'd0, y}, {24'd0, exp_q.pop_front()});
                chk("bounce_x", {28'd0, x}, 32'hE);
            end else begin
                chk("bounce_done", {31'd0, done}, 32'd1);
            end
        end
        @(negedge clk);
        chk("bounce_done_count", done_cnt - done_base, 32'd1);

        // stop in 5th RUN cycle
        done_base = done_cnt;
        start_seq(2'd0, 24'd0, 8'd3);
        @(negedge clk);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_x", {28'd0, x}, 32'hF);
        chk("stop_y", {24'd0, y}, 32'hFF);
        chk("stop_tick", {31'd0, step_tick}, 32'd0);
        repeat (3) @(negedge clk);
        chk("stop_no_done", done_cnt - done_base, 32'd0);

        // start with stop in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("ss_busy2", {31'd0, busy}, 32'd0);
        chk("ss_y", {24'd0, y}, 32'hFF);

        // reset mid-RUN
        done_base = done_cnt;
        start_seq(2'd2, 24'd0, 8'd5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rrun_busy", {31'd0, busy}, 32'd0);
        chk("rrun_done", {31'd0, done}, 32'd0);
        chk("rrun_x", {28'd0, x}, 32'hF);
        chk("rrun_y", {24'd0, y}, 32'hFF);
        repeat (2) @(negedge clk);
        chk("rrun_no_done", done_cnt - done_base, 32'd0);

        // frames=0
        done_base = done_cnt;
        start_seq(2'd2, 24'd0, 8'd0);
        @(negedge clk);
`ifdef LED_SEQ_LOOP_EN
        for (int k = 1; k <= 200; k++) begin
            wait_tick(4, cyc);
        end
        @(negedge clk);
        chk("loop_busy", {31'd0, busy}, 32'd1);
        chk("loop_no_done", done_cnt - done_base, 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("loop_stop_busy", {31'd0, busy}, 32'd0);
        chk("loop_stop_y", {24'd0, y}, 32'hFF);
`else
        for (int k = 1; k <= 2; k++) begin
            wait_tick(4, cyc);
            chk("f0_done", {31'd0, done}, (k == 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("f0_done_count", done_cnt - done_base, 32'd1);
        chk("f0_busy", {31'd0, busy}, 32'd0);
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
